counter_updown_mod: RTL and testbench

Parametrised up/down counter. Replaces the fixed 4-bit free-running counter in the datapath.
- Configurable width and modulus.
- Wrap or saturate mode.
- Synchronous parallel load, count enable, direction control.
- Terminal-count and wrap-event flags for cascading and for driving downstream timers and sequencers.

---
 rtl/counter_updown_mod.sv | 72 +++++++
 tb/tb_counter_updown_mod.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter with wrap or saturate at the range limits,
// synchronous clamped load, and terminal-count / wrap-event flags for cascading.
module counter_updown_mod #(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULO   = 16,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] Q,
    output logic             terminal_count,
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $fatal(1, "counter_updown_mod: WIDTH must be in 2..32");
    end
    if (MODULO < 2 || MODULO > (64'd1 << WIDTH)) begin : g_bad_modulo
        $fatal(1, "counter_updown_mod: MODULO must be in 2..2^WIDTH");
    end

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULO - 64'd1);

    logic             at_top;
    logic             at_bot;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;

    assign at_top         = (Q == MAXV);
    assign at_bot         = (Q == '0);
    assign terminal_count = up_down ? at_top : at_bot;

    // Saturation holds Q but still reports the limit hit on wrap.
    always_comb begin
        q_next    = Q;
        wrap_next = 1'b0;
        if (load) begin
            q_next = (load_value > MAXV) ? MAXV : load_value;
        end else if (enable) begin
            if (up_down) begin
                if (at_top) begin
                    wrap_next = 1'b1;
                    q_next    = SATURATE ? Q : '0;
                end else begin
                    q_next = Q + WIDTH'(1);
                end
            end else begin
                if (at_bot) begin
                    wrap_next = 1'b1;
                    q_next    = SATURATE ? Q : MAXV;
                end else begin
                    q_next = Q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            Q    <= '0;
            wrap <= 1'b0;
        end else begin
            Q    <= q_next;
            wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod: three parameterisations share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_counter_updown_mod;

    logic       clock = 1'b0;
    logic       clear = 1'b0;
    logic       enable = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_value = '0;

    logic [3:0] q0, q1, q2;
    logic       tc0, tc1, tc2;
    logic       w0, w1, w2;

    always #5 clock = ~clock;

    counter_updown_mod #(.WIDTH(4), .MODULO(16), .SATURATE(1'b0)) u_def (
        .clock(clock), .clear(clear), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .Q(q0), .terminal_count(tc0), .wrap(w0));

    counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_m10 (
        .clock(clock), .clear(clear), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .Q(q1), .terminal_count(tc1), .wrap(w1));

    counter_updown_mod #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_sat (
        .clock(clock), .clear(clear), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .Q(q2), .terminal_count(tc2), .wrap(w2));

    int checks = 0;
    int errors = 0;

    int mm[3] = '{16, 10, 10};
    bit ms[3] = '{1'b0, 1'b0, 1'b1};
    int mq[3];
    bit mw[3];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int dq(input int i);
        return (i == 0) ? int'(q0) : (i == 1) ? int'(q1) : int'(q2);
    endfunction

    function automatic int dw(input int i);
        return (i == 0) ? int'(w0) : (i == 1) ? int'(w1) : int'(w2);
    endfunction

    function automatic int dt(input int i);
        return (i == 0) ? int'(tc0) : (i == 1) ? int'(tc1) : int'(tc2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i] = 0;
            mw[i] = 1'b0;
        end
    endtask

    // Unbounded step, then fold back into 0..M-1 (or refuse the step when saturating).
    task automatic model_step();
        int t;
        for (int i = 0; i < 3; i++) begin
            if (load) begin
                mq[i] = (int'(load_value) > mm[i] - 1) ? mm[i] - 1 : int'(load_value);
                mw[i] = 1'b0;
            end else if (enable) begin
                t = mq[i] + (up_down ? 1 : -1);
                if (t < 0 || t >= mm[i]) begin
                    mw[i] = 1'b1;
                    if (!ms[i]) mq[i] = (t + mm[i]) % mm[i];
                end else begin
                    mq[i] = t;
                    mw[i] = 1'b0;
                end
            end else begin
                mw[i] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        int exp_tc;
        for (int i = 0; i < 3; i++) begin
            exp_tc = up_down ? int'(mq[i] == mm[i] - 1) : int'(mq[i] == 0);
            check($sformatf("model_q%0d", i), dq(i), mq[i]);
            check($sformatf("model_wrap%0d", i), dw(i), int'(mw[i]));
            check($sformatf("model_tc%0d", i), dt(i), exp_tc);
        end
    endtask

    task automatic tick(input bit en, input bit ud, input bit ld, input int lv);
        enable     = en;
        up_down    = ud;
        load       = ld;
        load_value = 4'(lv);
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    // Called at a falling edge: clear is asserted and released well before the next rising edge.
    task automatic pulse_clear();
        clear = 1'b0;
        #1;
        model_reset();
        check("clear_async_q", int'(q0), 0);
        check("clear_async_wrap", int'(w0), 0);
        compare_all();
        #1;
        clear = 1'b1;
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        check("reset_q", int'(q0), 0);
        check("reset_wrap", int'(w0), 0);
        check("reset_tc_up", int'(tc0), 0);
        compare_all();
        clear = 1'b1;

        // reset mid-count
        repeat (7) tick(1, 1, 0, 0);
        check("midcount_q", int'(q0), 7);
        pulse_clear();
        tick(1, 1, 0, 0);
        check("after_clear_q", int'(q0), 1);

        // wrap up, defaults
        tick(0, 1, 1, 14);
        check("wu_load_q", int'(q0), 14);
        tick(1, 1, 0, 0);
        check("wu_q15", int'(q0), 15);
        check("wu_tc15", int'(tc0), 1);
        check("wu_wrap15", int'(w0), 0);
        tick(1, 1, 0, 0);
        check("wu_q0", int'(q0), 0);
        check("wu_wrap0", int'(w0), 1);
        tick(1, 1, 0, 0);
        check("wu_q1", int'(q0), 1);
        check("wu_wrap1", int'(w0), 0);

        // wrap down, MODULO=10
        tick(0, 0, 1, 1);
        check("wd_load_q", int'(q1), 1);
        tick(1, 0, 0, 0);
        check("wd_q0", int'(q1), 0);
        check("wd_wrap0", int'(w1), 0);
        tick(1, 0, 0, 0);
        check("wd_q9", int'(q1), 9);
        check("wd_wrap9", int'(w1), 1);
        tick(1, 0, 0, 0);
        check("wd_q8", int'(q1), 8);
        check("wd_wrap8", int'(w1), 0);

        // saturate, MODULO=10
        tick(0, 1, 1, 8);
        check("sat_load_q", int'(q2), 8);
        tick(1, 1, 0, 0);
        check("sat_e1_q", int'(q2), 9);
        check("sat_e1_wrap", int'(w2), 0);
        check("sat_e1_tc", int'(tc2), 1);
        tick(1, 1, 0, 0);
        check("sat_e2_q", int'(q2), 9);
        check("sat_e2_wrap", int'(w2), 1);
        tick(1, 1, 0, 0);
        check("sat_e3_q", int'(q2), 9);
        check("sat_e3_wrap", int'(w2), 1);
        tick(1, 0, 0, 0);
        check("sat_down_q", int'(q2), 8);
        check("sat_down_wrap", int'(w2), 0);

        // load clamp and priority over enable
        tick(1, 1, 1, 12);
        check("clamp_q", int'(q1), 9);
        check("clamp_wrap", int'(w1), 0);
        check("clamp_def_q", int'(q0), 12);
        tick(0, 1, 0, 0);
        check("clamp_hold_q", int'(q1), 9);

        // enable gating
        tick(0, 1, 1, 3);
        tick(1, 1, 0, 0);
        check("gate_e1", int'(q0), 4);
        tick(0, 1, 0, 0);
        check("gate_e0a", int'(q0), 4);
        tick(1, 1, 0, 0);
        check("gate_e1b", int'(q0), 5);
        tick(0, 1, 0, 0);
        check("gate_e0b", int'(q0), 5);
        check("gate_wrap", int'(w0), 0);

        // randomized traffic
        repeat (400) begin
            tick($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 49) == 0) pulse_clear();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
